alu_issue_sched: RTL and testbench

- Reservation-station scheduler in front of the single combinational ALU.
- Buffers dispatched ALU-class ops (CAL, CALi, BRA, JUM) and snoops two broadcast buses for pending operands.
- Each cycle it selects one ready entry and drives the ALU inputs from registers.
- Sits between the decoder/dispatch stage and the ALU; the ALU result returns to the ROB and the CDB.

---
 rtl/alu_issue_sched.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sched.sv
// alu_issue_sched: reservation station that buffers ALU-class ops, snoops two CDBs and issues one ready op per cycle
// Ports: clk/rst_n (async active-low), rdy global enable, clr flush.
//   dis_*  : dispatch request with operands, pending tags, imm, pc and destination tag; rs_full when no slot is free.
//   cdb0_* / cdb1_* : result broadcasts (cdb0 = ALU, cdb1 = LSB); cdb0 wins when both match.
//   alu_*  : registered ALU operands; alu_run marks a launched op, data outputs hold when idle.
// Optional: define ALU_ISSUE_PERF_EN to add perf_issue and perf_full_stall counters.
module alu_issue_sched #(
    parameter int RS_SZ     = 16,
    parameter int RS_SZ_LOG = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             clr,
    input  logic             dis_valid,
    input  logic [3:0]       dis_optype,
    input  logic [3:0]       dis_opcode,
    input  logic [31:0]      dis_vj,
    input  logic [31:0]      dis_vk,
    input  logic             dis_qj_busy,
    input  logic             dis_qk_busy,
    input  logic [TAG_W-1:0] dis_qj,
    input  logic [TAG_W-1:0] dis_qk,
    input  logic [31:0]      dis_imm,
    input  logic [31:0]      dis_pc,
    input  logic [TAG_W-1:0] dis_rd,
    output logic             rs_full,
    input  logic             cdb0_valid,
    input  logic [TAG_W-1:0] cdb0_tag,
    input  logic [31:0]      cdb0_val,
    input  logic             cdb1_valid,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic [31:0]      cdb1_val,
    output logic             alu_run,
    output logic [31:0]      alu_vj,
    output logic [31:0]      alu_vk,
    output logic [31:0]      alu_imm,
    output logic [31:0]      alu_pc,
    output logic [3:0]       alu_opcode,
    output logic [3:0]       alu_optype,
    output logic [TAG_W-1:0] alu_rd
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]      perf_issue,
    output logic [31:0]      perf_full_stall
`endif
);
    logic [RS_SZ-1:0]   valid, busy_j, busy_k;
    logic [3:0]         e_optype [RS_SZ];
    logic [3:0]         e_opcode [RS_SZ];
    logic [31:0]        e_vj     [RS_SZ];
    logic [31:0]        e_vk     [RS_SZ];
    logic [31:0]        e_imm    [RS_SZ];
    logic [31:0]        e_pc     [RS_SZ];
    logic [TAG_W-1:0]   e_qj     [RS_SZ];
    logic [TAG_W-1:0]   e_qk     [RS_SZ];
    logic [TAG_W-1:0]   e_rd     [RS_SZ];
    logic [RS_SZ_LOG:0] cnt;
    logic [RS_SZ_LOG-1:0] free_idx, sel_idx;
    logic               has_sel, dis_go;
    logic               j0, j1, k0, k1;
    // Descending scan so the last hit is the lowest index; all searches use registered state only.
    always_comb begin
        cnt      = '0;
        free_idx = '0;
        sel_idx  = '0;
        has_sel  = 1'b0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            cnt = cnt + (RS_SZ_LOG + 1)'(valid[i]);
            if (!valid[i]) free_idx = RS_SZ_LOG'(i);
            if (valid[i] && !busy_j[i] && !busy_k[i]) begin
                sel_idx = RS_SZ_LOG'(i);
                has_sel = 1'b1;
            end
        end
    end
    assign rs_full = cnt == (RS_SZ_LOG + 1)'(RS_SZ);
    assign dis_go  = dis_valid && !rs_full && rdy && !clr;
    // Dispatch-time bypass: an operand broadcast in the dispatch cycle is captured directly.
    assign j0 = dis_qj_busy && cdb0_valid && cdb0_tag == dis_qj;
    assign j1 = dis_qj_busy && cdb1_valid && cdb1_tag == dis_qj;
    assign k0 = dis_qk_busy && cdb0_valid && cdb0_tag == dis_qk;
    assign k1 = dis_qk_busy && cdb1_valid && cdb1_tag == dis_qk;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            alu_run    <= 1'b0;
            alu_vj     <= '0;
            alu_vk     <= '0;
            alu_imm    <= '0;
            alu_pc     <= '0;
            alu_opcode <= '0;
            alu_optype <= '0;
            alu_rd     <= '0;
        end else if (rdy) begin
            if (clr) begin
                valid   <= '0;
                alu_run <= 1'b0;
            end else begin
                alu_run <= has_sel;
                if (has_sel) begin
                    valid[sel_idx] <= 1'b0;
                    alu_vj         <= e_vj[sel_idx];
                    alu_vk         <= e_vk[sel_idx];
                    alu_imm        <= e_imm[sel_idx];
                    alu_pc         <= e_pc[sel_idx];
                    alu_opcode     <= e_opcode[sel_idx];
                    alu_optype     <= e_optype[sel_idx];
                    alu_rd         <= e_rd[sel_idx];
                end
                // free_idx is an invalid slot, so it never collides with sel_idx.
                if (dis_go) valid[free_idx] <= 1'b1;
            end
        end
    end
    // Payload needs no reset: it is only observed through valid.
    always_ff @(posedge clk) begin
        if (rdy && !clr) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (valid[i] && busy_j[i]) begin
                    if (cdb0_valid && cdb0_tag == e_qj[i]) begin
                        e_vj[i]   <= cdb0_val;
                        busy_j[i] <= 1'b0;
                    end else if (cdb1_valid && cdb1_tag == e_qj[i]) begin
                        e_vj[i]   <= cdb1_val;
                        busy_j[i] <= 1'b0;
                    end
                end
                if (valid[i] && busy_k[i]) begin
                    if (cdb0_valid && cdb0_tag == e_qk[i]) begin
                        e_vk[i]   <= cdb0_val;
                        busy_k[i] <= 1'b0;
                    end else if (cdb1_valid && cdb1_tag == e_qk[i]) begin
                        e_vk[i]   <= cdb1_val;
                        busy_k[i] <= 1'b0;
                    end
                end
            end
            if (dis_go) begin
                e_optype[free_idx] <= dis_optype;
                e_opcode[free_idx] <= dis_opcode;
                e_vj[free_idx]     <= j0 ? cdb0_val : j1 ? cdb1_val : dis_vj;
                e_vk[free_idx]     <= k0 ? cdb0_val : k1 ? cdb1_val : dis_vk;
                busy_j[free_idx]   <= dis_qj_busy && !j0 && !j1;
                busy_k[free_idx]   <= dis_qk_busy && !k0 && !k1;
                e_qj[free_idx]     <= dis_qj;
                e_qk[free_idx]     <= dis_qk;
                e_imm[free_idx]    <= dis_imm;
                e_pc[free_idx]     <= dis_pc;
                e_rd[free_idx]     <= dis_rd;
            end
        end
    end
`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue      <= '0;
            perf_full_stall <= '0;
        end else if (rdy) begin
            if (has_sel && !clr) perf_issue <= perf_issue + 32'd1;
            if (dis_valid && rs_full) perf_full_stall <= perf_full_stall + 32'd1;
        end
    end
`else
    // Counters absent: no extra state or ports.
`endif
endmodule

// File: tb/tb_alu_issue_sched.sv
// tb_alu_issue_sched: directed bench for the ALU reservation-station scheduler
module tb_alu_issue_sched;
    logic        clk = 1'b0;
    logic        rst_n, rdy, clr;
    logic        dis_valid, dis_qj_busy, dis_qk_busy;
    logic [3:0]  dis_optype, dis_opcode, dis_qj, dis_qk, dis_rd;
    logic [31:0] dis_vj, dis_vk, dis_imm, dis_pc;
    logic        rs_full;
    logic        cdb0_valid, cdb1_valid;
    logic [3:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_val, cdb1_val;
    logic        alu_run;
    logic [31:0] alu_vj, alu_vk, alu_imm, alu_pc;
    logic [3:0]  alu_opcode, alu_optype, alu_rd;
    int checks = 0;
    int failures = 0;

    alu_issue_sched #(.RS_SZ(16), .RS_SZ_LOG(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clr(clr),
        .dis_valid(dis_valid), .dis_optype(dis_optype), .dis_opcode(dis_opcode),
        .dis_vj(dis_vj), .dis_vk(dis_vk), .dis_qj_busy(dis_qj_busy), .dis_qk_busy(dis_qk_busy),
        .dis_qj(dis_qj), .dis_qk(dis_qk), .dis_imm(dis_imm), .dis_pc(dis_pc), .dis_rd(dis_rd),
        .rs_full(rs_full),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_val(cdb0_val),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_val(cdb1_val),
        .alu_run(alu_run), .alu_vj(alu_vj), .alu_vk(alu_vk), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_opcode(alu_opcode), .alu_optype(alu_optype), .alu_rd(alu_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dis_valid  = 1'b0;
        cdb0_valid = 1'b0;
        cdb1_valid = 1'b0;
        clr        = 1'b0;
    endtask

    task automatic dispatch(input logic [3:0] ty, input logic [3:0] op, input logic [31:0] vj,
                            input logic [31:0] vk, input logic bj, input logic [3:0] qj,
                            input logic bk, input logic [3:0] qk, input logic [3:0] rd);
        dis_valid   = 1'b1;
        dis_optype  = ty;
        dis_opcode  = op;
        dis_vj      = vj;
        dis_vk      = vk;
        dis_qj_busy = bj;
        dis_qj      = qj;
        dis_qk_busy = bk;
        dis_qk      = qk;
        dis_rd      = rd;
        dis_imm     = 32'h1000 + 32'(rd);
        dis_pc      = 32'h2000 + 32'(rd);
    endtask

    task automatic cdb(input int bus, input logic [3:0] tag, input logic [31:0] val);
        if (bus == 0) begin
            cdb0_valid = 1'b1;
            cdb0_tag   = tag;
            cdb0_val   = val;
        end else begin
            cdb1_valid = 1'b1;
            cdb1_tag   = tag;
            cdb1_val   = val;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rdy = 1'b1;
        dispatch(4'd0, 4'd0, 0, 0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        cdb0_tag = 0; cdb0_val = 0; cdb1_tag = 0; cdb1_val = 0;
        idle();
        step();
        check("rst_run", alu_run, 0);
        check("rst_full", rs_full, 0);
        check("rst_vj", alu_vj, 0);
        check("rst_rd", alu_rd, 0);
        check("rst_imm", alu_imm, 0);
        rst_n = 1'b1;
        step();

        // ready ADD: dispatch cycle 0, issue visible cycle 2
        dispatch(4'd1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        step();
        idle();
        check("add_c1_run", alu_run, 0);
        step();
        check("add_run", alu_run, 1);
        check("add_vj", alu_vj, 5);
        check("add_vk", alu_vk, 7);
        check("add_rd", alu_rd, 3);
        check("add_imm", alu_imm, 32'h1003);
        check("add_pc", alu_pc, 32'h2003);
        check("add_optype", alu_optype, 1);
        step();
        check("add_after_run", alu_run, 0);
        check("add_hold_vj", alu_vj, 5);

        // SUB waiting on tag 6, woken by cdb1
        dispatch(4'd1, 4'd1, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 4'd4);
        step();
        idle();
        step();
        check("sub_wait1", alu_run, 0);
        step();
        check("sub_wait2", alu_run, 0);
        cdb(1, 4'd6, 32'h10);
        step();
        idle();
        check("sub_cdb_c1", alu_run, 0);
        step();
        check("sub_run", alu_run, 1);
        check("sub_vj", alu_vj, 32'h10);
        check("sub_opcode", alu_opcode, 1);
        check("sub_rd", alu_rd, 4);

        // dispatch bypass on k; cdb0 beats cdb1 on the same tag
        dispatch(4'd2, 4'd3, 32'd9, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd5);
        cdb(0, 4'd2, 32'hAB);
        cdb(1, 4'd2, 32'hCD);
        step();
        idle();
        check("byp_c1", alu_run, 0);
        step();
        check("byp_run", alu_run, 1);
        check("byp_vk", alu_vk, 32'hAB);
        check("byp_rd", alu_rd, 5);
        step();
        check("byp_after", alu_run, 0);

        // fill all 16 slots, each blocked on tag == slot
        for (int i = 0; i < 16; i++) begin
            dispatch(4'd1, 4'd0, 32'd0, 32'd0, 1'b1, 4'(i), 1'b0, 4'd0, 4'(i));
            step();
            check($sformatf("fill_full_%0d", i), rs_full, (i == 15) ? 1 : 0);
        end
        idle();
        // dropped dispatch while full, while slot 9 is woken and issues
        dispatch(4'd1, 4'd0, 32'h77, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'hE);
        cdb(0, 4'd9, 32'h99);
        step();
        cdb0_valid = 1'b0;
        check("full_still", rs_full, 1);
        check("full_norun", alu_run, 0);
        step();
        check("w9_run", alu_run, 1);
        check("w9_rd", alu_rd, 9);
        check("w9_vj", alu_vj, 32'h99);
        check("w9_full", rs_full, 0);
        dispatch(4'd1, 4'd0, 32'h55, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'hD);
        step();
        idle();
        check("refill_full", rs_full, 1);
        check("refill_norun", alu_run, 0);
        step();
        check("refill_run", alu_run, 1);
        check("refill_rd", alu_rd, 4'hD);
        check("refill_vj", alu_vj, 32'h55);
        check("refill_full2", rs_full, 0);
        step();
        check("drop_norun", alu_run, 0);

        // entries 2 and 5 ready together: lowest index first
        cdb(0, 4'd2, 32'h22);
        cdb(1, 4'd5, 32'h55);
        step();
        idle();
        check("pri_c1", alu_run, 0);
        step();
        check("pri_a_run", alu_run, 1);
        check("pri_a_rd", alu_rd, 2);
        check("pri_a_vj", alu_vj, 32'h22);
        step();
        check("pri_b_run", alu_run, 1);
        check("pri_b_rd", alu_rd, 5);
        check("pri_b_vj", alu_vj, 32'h55);
        step();
        check("pri_after", alu_run, 0);

        // flush everything, then flush with 3 entries and one issuing
        clr = 1'b1;
        step();
        idle();
        check("clr0_full", rs_full, 0);
        dispatch(4'd1, 4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd1);
        step();
        dispatch(4'd1, 4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0, 4'd2);
        step();
        dispatch(4'd1, 4'd0, 32'h70, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        step();
        idle();
        clr = 1'b1;
        step();
        idle();
        check("clr_run", alu_run, 0);
        check("clr_full", rs_full, 0);
        check("clr_rd_hold", alu_rd, 5);
        cdb(0, 4'd1, 32'h11);
        step();
        idle();
        check("clr_post1", alu_run, 0);
        step();
        check("clr_post2", alu_run, 0);
        step();
        check("clr_post3", alu_run, 0);

        // rdy=0 blocks dispatch and holds alu_run
        rdy = 1'b0;
        dispatch(4'd1, 4'd0, 32'hA0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'hA);
        step();
        step();
        idle();
        rdy = 1'b1;
        step();
        check("rdy0_nodis", alu_run, 0);
        step();
        check("rdy0_nodis2", alu_run, 0);
        dispatch(4'd1, 4'd0, 32'hB0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'hB);
        step();
        idle();
        step();
        check("rdy_run", alu_run, 1);
        check("rdy_rd", alu_rd, 4'hB);
        rdy = 1'b0;
        step();
        check("rdy0_hold", alu_run, 1);
        rdy = 1'b1;
        step();
        check("rdy1_idle", alu_run, 0);

        // async reset mid-operation
        dispatch(4'd1, 4'd0, 32'hC0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'hC);
        step();
        idle();
        #1 rst_n = 1'b0;
        #1;
        check("mrst_run", alu_run, 0);
        check("mrst_rd", alu_rd, 0);
        check("mrst_full", rs_full, 0);
        step();
        rst_n = 1'b1;
        step();
        check("mrst_noissue", alu_run, 0);
        step();
        check("mrst_noissue2", alu_run, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
